// File: rtl/coin_pkg.sv
// Shared definitions for the coin front-end and the vending controller.
//   MONEY_W    : width of the money code
//   MONEY_NONE : no coin (also the idle value of the money bus)
//   MONEY_HALF : 0.5 yuan
//   MONEY_ONE  : 1 yuan
package coin_pkg;

  localparam int MONEY_W = 2;

  typedef enum logic [MONEY_W-1:0] {
    MONEY_NONE = 2'b00,
    MONEY_HALF = 2'b01,
    MONEY_ONE  = 2'b10
  } money_e;

endpackage

// File: rtl/coin_input_conditioner_key_debounce.sv
// key_debounce: two-flop synchroniser plus counter debouncer for one raw button.
//   clk       in  system clock
//   clr       in  synchronous active-high reset
//   key_raw   in  asynchronous raw button level, active-high
//   key_level out debounced button level
//   key_press out one-cycle pulse on each 0->1 change of key_level
// A button still held when reset is released does not produce a press.
// Presses are re-armed only after the synchronised input has been seen low
// and the debounced level is back at 0.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            prime1_q, prime1_d;
  logic            prime2_q, prime2_d;
  logic            block_q, block_d;

  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    // prime2 marks that sync2 now reflects a post-reset sample of the button.
    prime1_d = 1'b1;
    prime2_d = prime1_q;
    cnt_d    = '0;
    level_d  = level_q;
    press_d  = 1'b0;
    block_d  = block_q;

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q & ~block_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (block_q && prime2_q && !sync2_q && !level_q) begin
      block_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      prime1_q <= 1'b0;
      prime2_q <= 1'b0;
      block_q  <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      prime1_q <= prime1_d;
      prime2_q <= prime2_d;
      block_q  <= block_d;
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces the two raw coin buttons, arbitrates their
// press events through a one-entry skid register and queues them in a FIFO that
// is presented to the vending controller as a money code with valid/ready.
//   clk         in  system clock
//   clr         in  synchronous active-high reset
//   hfyen       in  raw 0.5-yuan button (async)
//   oneyen      in  raw 1-yuan button (async)
//   money_ready in  consumer takes the head entry this cycle
//   money_valid out FIFO head valid
//   money       out money code (MONEY_NONE when not valid)
//   fifo_full   out FIFO holds DEPTH entries
//   dropped     out one-cycle pulse, a coin was lost to a full FIFO
//   tally       out accepted value in half-yuan units, saturating at 255
//                   (present only when COIN_TALLY_EN is defined)
// Optional feature macro: COIN_TALLY_EN.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               hfyen,
  input  logic               oneyen,
  input  logic               money_ready,
  output logic               money_valid,
  output logic [MONEY_W-1:0] money,
  output logic               fifo_full,
  output logic               dropped
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0]         tally
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic half_level, half_press, one_level, one_press;
  logic half_ev, one_ev;

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_half (
    .clk       (clk),
    .clr       (clr),
    .key_raw   (hfyen),
    .key_level (half_level),
    .key_press (half_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_one (
    .clk       (clk),
    .clr       (clr),
    .key_raw   (oneyen),
    .key_level (one_level),
    .key_press (one_press)
  );

  // A press pulse always coincides with the debounced level being high.
  assign half_ev = half_press & half_level;
  assign one_ev  = one_press & one_level;

  logic               skid_vld_q, skid_vld_d;
  logic [MONEY_W-1:0] skid_code_q, skid_code_d;
  logic               push_req;
  logic [MONEY_W-1:0] push_code;

  // The skid entry goes first. A button cannot press again in the cycle right
  // after its own press, so while the skid is occupied at most one new event
  // can arrive, and it takes the skid slot for the following cycle.
  always_comb begin
    push_req    = 1'b0;
    push_code   = MONEY_NONE;
    skid_vld_d  = 1'b0;
    skid_code_d = skid_code_q;
    if (skid_vld_q) begin
      push_req  = 1'b1;
      push_code = skid_code_q;
      if (half_ev) begin
        skid_vld_d  = 1'b1;
        skid_code_d = MONEY_HALF;
      end else if (one_ev) begin
        skid_vld_d  = 1'b1;
        skid_code_d = MONEY_ONE;
      end
    end else if (half_ev) begin
      push_req  = 1'b1;
      push_code = MONEY_HALF;
      if (one_ev) begin
        skid_vld_d  = 1'b1;
        skid_code_d = MONEY_ONE;
      end
    end else if (one_ev) begin
      push_req  = 1'b1;
      push_code = MONEY_ONE;
    end
  end

  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MONEY_W-1:0] mem_q [DEPTH];
  logic               dropped_q, dropped_d;
  logic               empty, full, pop, push_ok;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal index
  // with differing wrap bits means full.
  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop       = ~empty & money_ready;
    push_ok   = push_req & (~full | pop);
    dropped_d = push_req & full & ~pop;
    wptr_d    = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      skid_vld_q  <= 1'b0;
      skid_code_q <= MONEY_NONE;
      dropped_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      skid_vld_q  <= skid_vld_d;
      skid_code_q <= skid_code_d;
      dropped_q   <= dropped_d;
    end
  end

  // When full with a simultaneous pop, the write slot is the one being read;
  // the head is consumed this cycle and overwritten at the edge.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= push_code;
    end
  end

  assign money_valid = ~empty;
  assign money       = empty ? MONEY_NONE : mem_q[rptr_q[AW-1:0]];
  assign fifo_full   = full;
  assign dropped     = dropped_q;

`ifdef COIN_TALLY_EN
  logic [7:0] tally_q, tally_d;

  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_comb begin
    tally_d = tally_q;
    if (push_ok) begin
      tally_d = sat_add8(tally_q, (push_code == MONEY_ONE) ? 2'd2 : 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign tally = tally_q;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DB_CYCLES=4, DEPTH=4.
module tb_coin_input_conditioner;

  logic       clk = 1'b0;
  logic       clr;
  logic       hfyen;
  logic       oneyen;
  logic       money_ready;
  logic       money_valid;
  logic [1:0] money;
  logic       fifo_full;
  logic       dropped;
`ifdef COIN_TALLY_EN
  logic [7:0] tally;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DB_CYCLES(4), .DB_W(3), .DEPTH(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .hfyen       (hfyen),
    .oneyen      (oneyen),
    .money_ready (money_ready),
    .money_valid (money_valid),
    .money       (money),
    .fifo_full   (fifo_full),
    .dropped     (dropped)
`ifdef COIN_TALLY_EN
    ,
    .tally       (tally)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full clean press of one button: pushed 7 cycles after the raw edge,
  // release settles well within the low phase.
  task automatic press_half();
    hfyen = 1'b1;
    tick(8);
    hfyen = 1'b0;
    tick(8);
  endtask

  initial begin
    clr = 1'b1; hfyen = 1'b0; oneyen = 1'b0; money_ready = 1'b0;
    tick(2);
    clr = 1'b0;
    chk("rst_valid", money_valid, 0);
    chk("rst_money", money, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_dropped", dropped, 0);
`ifdef COIN_TALLY_EN
    chk("rst_tally", tally, 0);
`endif
    tick(4);

    // 1: clean half press
    hfyen = 1'b1;
    tick(5);
    chk("t1_early", money_valid, 0);
    tick(1);
    chk("t1_press", dut.u_db_half.key_press, 1);
    chk("t1_not_yet", money_valid, 0);
    tick(1);
    chk("t1_valid", money_valid, 1);
    chk("t1_money", money, 2'b01);
    money_ready = 1'b1;
    tick(1);
    money_ready = 1'b0;
    chk("t1_popped", money_valid, 0);
    chk("t1_money_idle", money, 0);
    tick(2);
    hfyen = 1'b0;
    tick(10);
    chk("t1_no_release_evt", money_valid, 0);

    // 2: bounce then hold on the one-yuan button
    for (int i = 0; i < 4; i++) begin
      oneyen = (i % 2 == 0);
      tick(1);
      chk("t2_bounce", money_valid, 0);
    end
    oneyen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t2_hold", money_valid, 0);
    end
    tick(1);
    chk("t2_valid", money_valid, 1);
    chk("t2_money", money, 2'b10);
    money_ready = 1'b1;
    tick(1);
    money_ready = 1'b0;
    tick(10);
    chk("t2_single", money_valid, 0);
    oneyen = 1'b0;
    tick(10);

    // 3: both buttons debounce in the same cycle
    hfyen = 1'b1;
    oneyen = 1'b1;
    tick(7);
    chk("t3_first_valid", money_valid, 1);
    chk("t3_first_money", money, 2'b01);
    money_ready = 1'b1;
    tick(1);
    chk("t3_second_valid", money_valid, 1);
    chk("t3_second_money", money, 2'b10);
    tick(1);
    money_ready = 1'b0;
    chk("t3_empty", money_valid, 0);
`ifdef COIN_TALLY_EN
    chk("t3_tally", tally, 6);
`endif
    hfyen = 1'b0;
    oneyen = 1'b0;
    tick(10);

    // 4: overflow with no consumer
    for (int i = 0; i < 3; i++) press_half();
    chk("t4_not_full", fifo_full, 0);
    press_half();
    chk("t4_full", fifo_full, 1);
    hfyen = 1'b1;
    tick(6);
    chk("t4_no_drop_yet", dropped, 0);
    tick(1);
    chk("t4_drop", dropped, 1);
    tick(1);
    chk("t4_drop_pulse", dropped, 0);
    hfyen = 1'b0;
    tick(8);
    chk("t4_still_full", fifo_full, 1);
`ifdef COIN_TALLY_EN
    chk("t4_tally", tally, 10);
`endif
    money_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_valid", money_valid, 1);
      chk("t4_drain_money", money, 2'b01);
      tick(1);
    end
    money_ready = 1'b0;
    chk("t4_drained", money_valid, 0);
    chk("t4_not_full_after", fifo_full, 0);

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) press_half();
    chk("t5_full", fifo_full, 1);
    oneyen = 1'b1;
    tick(6);
    money_ready = 1'b1;
    tick(1);
    money_ready = 1'b0;
    chk("t5_no_drop", dropped, 0);
    chk("t5_still_full", fifo_full, 1);
    tick(1);
    chk("t5_no_drop_late", dropped, 0);
    oneyen = 1'b0;
    tick(8);
`ifdef COIN_TALLY_EN
    chk("t5_tally", tally, 16);
`endif
    money_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_order_valid", money_valid, 1);
      chk("t5_order_money", money, (i == 3) ? 2'b10 : 2'b01);
      tick(1);
    end
    money_ready = 1'b0;
    chk("t5_drained", money_valid, 0);

    // 6: reset with queued entries and a debounce in progress
    for (int i = 0; i < 3; i++) press_half();
    chk("t6_queued", money_valid, 1);
    oneyen = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t6_valid", money_valid, 0);
    chk("t6_money", money, 0);
    chk("t6_full", fifo_full, 0);
    chk("t6_dropped", dropped, 0);
`ifdef COIN_TALLY_EN
    chk("t6_tally", tally, 0);
`endif
    tick(20);
    chk("t6_held_no_event", money_valid, 0);
    oneyen = 1'b0;
    tick(12);
    chk("t6_release_no_event", money_valid, 0);
    oneyen = 1'b1;
    tick(7);
    chk("t6_fresh_valid", money_valid, 1);
    chk("t6_fresh_money", money, 2'b10);
`ifdef COIN_TALLY_EN
    chk("t6_fresh_tally", tally, 2);
`endif
    money_ready = 1'b1;
    tick(1);
    money_ready = 1'b0;
    oneyen = 1'b0;
    chk("t6_final_empty", money_valid, 0);
    tick(10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
